// File: rtl/bus_decoder.sv
// Registered base/mask address decoder with per-region read latency and one transaction in flight.
// Optional: define BUS_DECODER_ERR_EN to flag unmapped accesses on err.
module bus_decoder #(
  parameter int NUM_REGIONS = 3,
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 32,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {14'h3000, 14'h2000, 14'h0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {14'h3F00, 14'h3000, 14'h2000},
  parameter logic [NUM_REGIONS*4-1:0]          REGION_LAT  = {4'd1, 4'd2, 4'd0}
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req,
  input  logic                              wen,
  input  logic                              ren,
  input  logic [ADDR_WIDTH-1:0]             addr,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              ready,
  output logic                              err,
  output logic [NUM_REGIONS-1:0]            sel,
  output logic [NUM_REGIONS-1:0]            wen_o,
  output logic [NUM_REGIONS-1:0]            ren_o,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] rdata_i
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    hit_reg;
  logic                    write_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;

  logic [NUM_REGIONS-1:0]  match;
  logic [IDX_W-1:0]        dec_idx;
  logic                    dec_hit;
  logic [3:0]              lat_arr    [NUM_REGIONS];
  logic [DATA_WIDTH-1:0]   slave_data [NUM_REGIONS];

  // Per-region decode, parameter slicing and strobe generation from latched values only.
  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      assign match[gi]      = (addr & REGION_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH])
                              == REGION_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign lat_arr[gi]    = REGION_LAT[gi*4 +: 4];
      assign slave_data[gi] = rdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sel[gi]        = (state_reg == STROBE) && hit_reg && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    dec_idx = '0;
    dec_hit = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        dec_idx = IDX_W'(i);
        dec_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req && (wen || ren)) state_next = STROBE;
      STROBE:  state_next = (!hit_reg || lat_arr[idx_reg] == 4'd0) ? DONE : WAIT;
      WAIT:    if (cnt_reg <= 4'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      hit_reg   <= 1'b0;
      write_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      if (state_reg == IDLE && state_next == STROBE) begin
        idx_reg   <= dec_idx;
        hit_reg   <= dec_hit;
        write_reg <= wen;
      end
      if (state_reg == STROBE) begin
        cnt_reg <= hit_reg ? lat_arr[idx_reg] : 4'd0;
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      // Slave data is sampled on the edge that enters DONE; writes and misses return zero.
      if (state_next == DONE && state_reg != DONE) begin
        rdata_reg <= (hit_reg && !write_reg) ? slave_data[idx_reg] : '0;
      end
    end
  end

  assign ready = (state_reg == DONE);
  assign rdata = ready ? rdata_reg : '0;
  assign wen_o = sel & {NUM_REGIONS{write_reg}};
  assign ren_o = sel & {NUM_REGIONS{~write_reg}};

`ifdef BUS_DECODER_ERR_EN
  assign err = ready && !hit_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: decode, latency, write/read strobes, misses, reset abort, back-to-back.
module tb_bus_decoder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        wen;
  logic        ren;
  logic [13:0] addr;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [2:0]  sel;
  logic [2:0]  wen_o;
  logic [2:0]  ren_o;
  logic [95:0] rdata_i;

  int errors = 0;
  int checks = 0;

`ifdef BUS_DECODER_ERR_EN
  localparam logic MISS_ERR = 1'b1;
`else
  localparam logic MISS_ERR = 1'b0;
`endif

  bus_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wen     (wen),
    .ren     (ren),
    .addr    (addr),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .sel     (sel),
    .wen_o   (wen_o),
    .ren_o   (ren_o),
    .rdata_i (rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " ready"}, 32'(ready), 32'd0);
    check({tag, " err"},   32'(err),   32'd0);
    check({tag, " rdata"}, rdata,      32'd0);
    check({tag, " sel"},   32'(sel),   32'd0);
    check({tag, " wen_o"}, 32'(wen_o), 32'd0);
    check({tag, " ren_o"}, 32'(ren_o), 32'd0);
  endtask

  task automatic txn(input string name, input logic w, input logic r, input logic [13:0] a,
                     input logic [2:0] exp_sel, input logic [2:0] exp_wen, input logic [2:0] exp_ren,
                     input int lat, input logic [31:0] exp_rdata, input logic exp_err);
    req = 1'b1; wen = w; ren = r; addr = a;
    @(posedge clk); #1;
    check({name, " strobe sel"},   32'(sel),   32'(exp_sel));
    check({name, " strobe wen_o"}, 32'(wen_o), 32'(exp_wen));
    check({name, " strobe ren_o"}, 32'(ren_o), 32'(exp_ren));
    check({name, " strobe ready"}, 32'(ready), 32'd0);
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      check({name, " wait ready"}, 32'(ready), 32'd0);
      check({name, " wait sel"},   32'(sel),   32'd0);
    end
    @(posedge clk); #1;
    check({name, " done ready"}, 32'(ready), 32'd1);
    check({name, " done rdata"}, rdata,      exp_rdata);
    check({name, " done err"},   32'(err),   32'(exp_err));
    check({name, " done sel"},   32'(sel),   32'd0);
    req = 1'b0; wen = 1'b0; ren = 1'b0;
    @(posedge clk); #1;
    check({name, " after ready"}, 32'(ready), 32'd0);
    check({name, " after rdata"}, rdata,      32'd0);
    $display("txn %s addr=%h wen=%0b ren=%0b rdata=%h err=%0b", name, a, w, r, exp_rdata, exp_err);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; wen = 1'b0; ren = 1'b0; addr = '0;
    rdata_i = {32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF};

    // Reset and idle
    #2;
    check_quiet("in_reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_quiet("idle");
    $display("txn reset/idle outputs checked");

    // req with neither wen nor ren must be ignored
    req = 1'b1; addr = 14'h0001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("noop sel",   32'(sel),   32'd0);
      check("noop ready", 32'(ready), 32'd0);
    end
    req = 1'b0;
    @(posedge clk); #1;
    $display("txn noop req ignored");

    txn("rd_r0",   1'b0, 1'b1, 14'h0001, 3'b001, 3'b000, 3'b001, 0, 32'hDEADBEEF, 1'b0);
    txn("wr_r1",   1'b1, 1'b1, 14'h2001, 3'b010, 3'b010, 3'b000, 2, 32'h0,        1'b0);
    txn("rd_r2",   1'b0, 1'b1, 14'h3000, 3'b100, 3'b000, 3'b100, 1, 32'h12345678, 1'b0);
    txn("rd_miss", 1'b0, 1'b1, 14'h3100, 3'b000, 3'b000, 3'b000, 0, 32'h0,        MISS_ERR);
    txn("wr_r0",   1'b1, 1'b0, 14'h0004, 3'b001, 3'b001, 3'b000, 0, 32'h0,        1'b0);
    txn("rd_r1",   1'b0, 1'b1, 14'h2ABC, 3'b010, 3'b000, 3'b010, 2, 32'hCAFEF00D, 1'b0);

    // Async reset mid-WAIT on a region1 read: no ready may follow
    req = 1'b1; ren = 1'b1; addr = 14'h2000;
    @(posedge clk); #1;
    check("abort_wait strobe ren_o", 32'(ren_o), 32'b010);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0; ren = 1'b0;
    #1;
    check_quiet("abort_wait");
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_wait no ready", 32'(ready), 32'd0);
    end
    $display("txn abort mid-WAIT addr=2000");

    // Async reset during STROBE: strobes must drop without waiting for a clock
    req = 1'b1; ren = 1'b1; addr = 14'h0000;
    @(posedge clk); #1;
    check("abort_strobe sel before", 32'(sel), 32'b001);
    rst = 1'b0; req = 1'b0; ren = 1'b0;
    #1;
    check_quiet("abort_strobe");
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_strobe no ready", 32'(ready), 32'd0);
    end
    $display("txn abort mid-STROBE addr=0000");

    // Back-to-back reads with req held: ready every third cycle
    req = 1'b1; ren = 1'b1; addr = 14'h0000;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      check("b2b ready", 32'(ready), (c % 3 == 2) ? 32'd1 : 32'd0);
      if (c % 3 == 2) check("b2b rdata", rdata, 32'hDEADBEEF);
      if (c % 3 == 1) check("b2b ren_o", 32'(ren_o), 32'b001);
    end
    req = 1'b0; ren = 1'b0;
    @(posedge clk); #1;
    check("b2b end sel", 32'(sel), 32'd0);
    $display("txn back-to-back reads addr=0000 x4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_decoder.md
# bus_decoder

Parametrised, registered address decoder and response mux between the rv32i core's data port and N memory-mapped slaves (RAM, peripherals). Generalises the fixed two-slave decoder to NUM_REGIONS base/mask regions with per-region read latency, a req/ready handshake and unmapped-access error reporting. It sits between the core load/store unit and the slave array, one transaction in flight.

## Interface
- NUM_REGIONS, 3: number of slave regions (1..8).
- ADDR_WIDTH, 14: address width.
- DATA_WIDTH, 32: data width.
- REGION_BASE, {14'h3000,14'h2000,14'h0000}: packed; region k is `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- REGION_MASK, {14'h3F00,14'h3000,14'h2000}: packed; region k hits when (addr & mask_k) == base_k.
- REGION_LAT, {4'd1,4'd2,4'd0}: packed 4-bit wait cycles per region, 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  master request, held until ready.
- wen  in  1  write request (wins if ren also high).
- ren  in  1  read request.
- addr  in  ADDR_WIDTH  byte address, held with req.
- rdata  out  DATA_WIDTH  read data, valid only while ready.
- ready  out  1  one-cycle completion pulse.
- err  out  1  unmapped access, valid with ready.
- sel  out  NUM_REGIONS  one-hot slave select, one-cycle strobe.
- wen_o  out  NUM_REGIONS  one-hot write strobe.
- ren_o  out  NUM_REGIONS  one-hot read strobe.
- rdata_i  in  NUM_REGIONS*DATA_WIDTH  packed slave read data.

## Operation
- FSM states: IDLE, STROBE, WAIT, DONE.
- IDLE: on req && (wen || ren), latch addr, decoded region index, hit flag, op, then go to STROBE. req with neither wen nor ren is ignored.
- Decode: lowest-index matching region wins on overlap; no match = miss.
- STROBE: on a hit, sel[k] and wen_o[k] or ren_o[k] are high for this cycle only; counter loads REGION_LAT[k]. If miss or latency 0, go to DONE; otherwise go to WAIT.
- WAIT: counter decrements each cycle; at 1 go to DONE.
- Entering DONE: for a read hit, capture rdata_i[k]; for a write or miss, capture zero.
- DONE: ready=1, rdata=captured value, err per Configuration; always return to IDLE. req is not sampled in DONE.
- Reset (any state, asynchronous): state=IDLE, counter=0. All outputs are 0: ready, err, rdata, sel, wen_o, ren_o. An aborted transaction produces no ready.

## Timing
- req sampled at edge T: strobes high in cycle T+1, ready high in cycle T+2+L, where L is the region latency. Miss: ready in cycle T+2.
- Back-to-back: next req is sampled at the first edge after DONE; minimum period is 3+L cycles.
- All outputs are registered or decoded from state/latched values only; no combinational path from addr or req to outputs.
- Slaves must hold rdata_i valid from the strobe until the DONE entry edge.

## Configuration
- BUS_DECODER_ERR_EN defined: a miss completes with err=1 and rdata=0.
- BUS_DECODER_ERR_EN undefined: a miss completes with the same timing, err tied 0 and rdata=0. Unmapped accesses are silently dropped.

## Test plan
- Reset then idle: all outputs 0. Assert rst low mid-WAIT (region1 read): outputs clear immediately and no ready follows.
- Read 14'h0001, rdata_i region0=32'hDEADBEEF: ren_o=3'b001 at T+1; ready at T+2 with rdata=32'hDEADBEEF, err=0.
- Write 14'h2001 with wen=ren=1: wen_o=3'b010 and ren_o=0 at T+1; ready at T+4.
- Read 14'h3000, region2=32'h12345678: ren_o=3'b100 at T+1; ready at T+3 with rdata=32'h12345678.
- Read 14'h3100 (unmapped): no strobes; ready at T+2, rdata=0. err=1 with BUS_DECODER_ERR_EN defined, err=0 without.
- Back-to-back reads to 14'h0000 with req held high: ready pulses every 3 cycles, never on consecutive cycles.
